// File: rtl/p_mult_pkg.sv
// Shared constants, width helper and stage record for the handshaked pipelined multiplier.
package p_mult_pkg;

    localparam int MIN_LATENCY = 2;
    localparam int ACC_GUARD   = 8;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TAG_W   = 4;

    function automatic int PRODUCT_W(input int w);
        return 2 * w;
    endfunction

    // One pipeline slot in the default configuration; data is the operand pair or the product.
    typedef struct packed {
        logic                     valid;
        logic                     is_signed;
        logic [DEF_TAG_W-1:0]     tag;
        logic [2*DEF_WIDTH-1:0]   data;
    } stage_t;

endpackage

// File: rtl/p_mult_pipe_reg.sv
// Stall-gated pipeline stage register with synchronous active-high reset.
module p_mult_pipe_reg
    import p_mult_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/p_multiplier_hs.sv
// Pipelined WIDTHxWIDTH multiplier with valid/ready handshake and global stall.
// Define PMULT_ACC_EN to add an output-stage accumulator (adds in_acc, res widens to ACC_W).
module p_multiplier_hs
    import p_mult_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 3,
    parameter int TAG_W   = 4,
    parameter int ACC_W   = 2 * WIDTH + ACC_GUARD,
`ifdef PMULT_ACC_EN
    localparam int RW     = ACC_W
`else
    localparam int RW     = 2 * WIDTH
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    input  logic [TAG_W-1:0] in_tag,
`ifdef PMULT_ACC_EN
    input  logic             in_acc,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    res,
    output logic [TAG_W-1:0] out_tag
);

    localparam int DW = PRODUCT_W(WIDTH);
`ifdef PMULT_ACC_EN
    localparam int NS = LATENCY - 1;
    localparam int ND = LATENCY - 1;
`else
    localparam int NS = 1;
    localparam int ND = LATENCY;
`endif

    logic                advance;
    logic [LATENCY-1:0]  v_q;
    logic [NS-1:0]       s_q;
    logic [TAG_W-1:0]    tag_q  [LATENCY];
    logic [DW-1:0]       data_q [ND];
    logic [DW-1:0]       op_a;
    logic [DW-1:0]       op_b;
    (* use_dsp = "yes" *) logic [DW-1:0] product;
`ifdef PMULT_ACC_EN
    logic [LATENCY-2:0]  af_q;
`endif

    if (LATENCY < MIN_LATENCY) begin : g_latency_check
        $error("p_multiplier_hs: LATENCY must be at least %0d", MIN_LATENCY);
    end

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Sign-extend only for signed pairs; the low DW bits of the widened product are then exact.
    assign op_a    = {{(DW-WIDTH){s_q[0] & data_q[0][DW-1]}}, data_q[0][DW-1:WIDTH]};
    assign op_b    = {{(DW-WIDTH){s_q[0] & data_q[0][WIDTH-1]}}, data_q[0][WIDTH-1:0]};
    assign product = op_a * op_b;

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        if (i == 0) begin : g_first
`ifdef PMULT_ACC_EN
            logic [3+TAG_W+DW-1:0] q;
            p_mult_pipe_reg #(.W(3 + TAG_W + DW)) u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (advance),
                .d     ({in_valid, in_signed, in_acc, in_tag, dataa, datab}),
                .q     (q)
            );
            assign {v_q[0], s_q[0], af_q[0], tag_q[0], data_q[0]} = q;
`else
            logic [2+TAG_W+DW-1:0] q;
            p_mult_pipe_reg #(.W(2 + TAG_W + DW)) u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (advance),
                .d     ({in_valid, in_signed, in_tag, dataa, datab}),
                .q     (q)
            );
            assign {v_q[0], s_q[0], tag_q[0], data_q[0]} = q;
`endif
`ifdef PMULT_ACC_EN
        end else if (i < LATENCY - 1) begin : g_mid
            logic [DW-1:0]         src;
            logic [3+TAG_W+DW-1:0] q;
            assign src = (i == 1) ? product : data_q[i-1];
            p_mult_pipe_reg #(.W(3 + TAG_W + DW)) u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (advance),
                .d     ({v_q[i-1], s_q[i-1], af_q[i-1], tag_q[i-1], src}),
                .q     (q)
            );
            assign {v_q[i], s_q[i], af_q[i], tag_q[i], data_q[i]} = q;
        end else begin : g_last
            // The product itself lives in the accumulator, so only valid and tag are staged here.
            logic [1+TAG_W-1:0] q;
            p_mult_pipe_reg #(.W(1 + TAG_W)) u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (advance),
                .d     ({v_q[i-1], tag_q[i-1]}),
                .q     (q)
            );
            assign {v_q[i], tag_q[i]} = q;
        end
`else
        end else begin : g_rest
            logic [DW-1:0]         src;
            logic [1+TAG_W+DW-1:0] q;
            assign src = (i == 1) ? product : data_q[i-1];
            p_mult_pipe_reg #(.W(1 + TAG_W + DW)) u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (advance),
                .d     ({v_q[i-1], tag_q[i-1], src}),
                .q     (q)
            );
            assign {v_q[i], tag_q[i], data_q[i]} = q;
        end
`endif
    end

`ifdef PMULT_ACC_EN
    logic [DW-1:0]    fin_data;
    logic [ACC_W-1:0] fin_ext;
    logic [ACC_W-1:0] acc;

    assign fin_data = (LATENCY == 2) ? product : data_q[LATENCY-2];
    assign fin_ext  = {{(ACC_W-DW){s_q[LATENCY-2] & fin_data[DW-1]}}, fin_data};

    // An output-stage load either restarts the total or adds onto it; bubbles and stalls hold it.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (advance && v_q[LATENCY-2]) begin
            acc <= (af_q[LATENCY-2] ? acc : '0) + fin_ext;
        end
    end

    assign res = acc;
`else
    assign res = data_q[LATENCY-1];
`endif

    assign out_valid = v_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];

endmodule

// File: tb/tb_p_multiplier_hs.sv
// Directed self-checking bench for p_multiplier_hs (WIDTH=8, LATENCY=3, TAG_W=4).
module tb_p_multiplier_hs;
    import p_mult_pkg::*;

    localparam int WIDTH   = 8;
    localparam int LATENCY = 3;
    localparam int TAG_W   = 4;
    localparam int PW      = PRODUCT_W(WIDTH);
`ifdef PMULT_ACC_EN
    localparam int RW      = PW + ACC_GUARD;
`else
    localparam int RW      = PW;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] dataa;
    logic [WIDTH-1:0] datab;
    logic [TAG_W-1:0] in_tag;
`ifdef PMULT_ACC_EN
    logic             in_acc;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    res;
    logic [TAG_W-1:0] out_tag;

    int errors = 0;
    int checks = 0;

    p_multiplier_hs #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY),
        .TAG_W   (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .dataa     (dataa),
        .datab     (datab),
        .in_tag    (in_tag),
`ifdef PMULT_ACC_EN
        .in_acc    (in_acc),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
        in_valid  = v;
        in_signed = s;
        dataa     = a;
        datab     = b;
        in_tag    = t;
`ifdef PMULT_ACC_EN
        in_acc    = 1'b0;
`endif
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0);
        step();
        step();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (res !== '0) begin
            errors++;
            $display("[TB] FAIL reset_res: got %h expected 0", res);
        end
        checks++;
        if (out_tag !== '0) begin
            errors++;
            $display("[TB] FAIL reset_out_tag: got %h expected 0", out_tag);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_unsigned();
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 8'd255, 8'd255, 4'd3);
        step();
        drive(1'b0, 1'b0, '0, '0, '0);
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL unsigned_early: out_valid got %b expected 0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL unsigned_latency: out_valid got %b expected 1", out_valid);
        end
        checks++;
        if (res[PW-1:0] !== 16'hFE01) begin
            errors++;
            $display("[TB] FAIL unsigned_res: got %h expected fe01", res[PW-1:0]);
        end
        checks++;
        if (out_tag !== 4'd3) begin
            errors++;
            $display("[TB] FAIL unsigned_tag: got %0d expected 3", out_tag);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL unsigned_single: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0]    exp_res [3];
        logic [TAG_W-1:0] exp_tag [3];
        exp_res[0] = 16'h4000; exp_tag[0] = 4'd5;
        exp_res[1] = 16'hFF81; exp_tag[1] = 4'd6;
        exp_res[2] = 16'h7E81; exp_tag[2] = 4'd7;
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 8'h80, 8'h80, 4'd5);
        step();
        drive(1'b1, 1'b1, 8'hFF, 8'h7F, 4'd6);
        step();
        drive(1'b1, 1'b0, 8'hFF, 8'h7F, 4'd7);
        step();
        drive(1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", i, out_valid);
            end
            checks++;
            if (res[PW-1:0] !== exp_res[i]) begin
                errors++;
                $display("[TB] FAIL b2b_res[%0d]: got %h expected %h", i, res[PW-1:0], exp_res[i]);
            end
            checks++;
            if (out_tag !== exp_tag[i]) begin
                errors++;
                $display("[TB] FAIL b2b_tag[%0d]: got %0d expected %0d", i, out_tag, exp_tag[i]);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_drain: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        stage_t           exp [5];
        logic [WIDTH-1:0] opa [5];
        logic [WIDTH-1:0] opb [5];
        logic [PW-1:0]    held_res;
        logic [TAG_W-1:0] held_tag;
        logic             was_held;
        int               n_in;
        int               n_out;
        int               stalls;
        int               extra;
        opa[0] = 8'd10;  opb[0] = 8'd20;  exp[0] = '{1'b1, 1'b0, 4'd1, 16'h00C8};
        opa[1] = 8'd100; opb[1] = 8'd3;   exp[1] = '{1'b1, 1'b0, 4'd2, 16'h012C};
        opa[2] = 8'd17;  opb[2] = 8'd17;  exp[2] = '{1'b1, 1'b0, 4'd3, 16'h0121};
        opa[3] = 8'd200; opb[3] = 8'd2;   exp[3] = '{1'b1, 1'b0, 4'd4, 16'h0190};
        opa[4] = 8'd12;  opb[4] = 8'd12;  exp[4] = '{1'b1, 1'b0, 4'd5, 16'h0090};
        n_in = 0; n_out = 0; stalls = 0; was_held = 1'b0;
        held_res = '0; held_tag = '0;
        for (int cyc = 0; cyc < 40 && n_out < 5; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (n_in < 5) drive(1'b1, 1'b0, opa[n_in], opb[n_in], exp[n_in].tag);
            else          drive(1'b0, 1'b0, '0, '0, '0);
            #3;
            if (was_held) begin
                checks++;
                if (out_valid !== 1'b1 || res[PW-1:0] !== held_res || out_tag !== held_tag) begin
                    errors++;
                    $display("[TB] FAIL bp_hold: got v=%b res=%h tag=%0d expected v=1 res=%h tag=%0d",
                             out_valid, res[PW-1:0], out_tag, held_res, held_tag);
                end
            end
            if (out_valid && !out_ready) begin
                stalls++;
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL bp_in_ready: got %b expected 0", in_ready);
                end
            end
            was_held = out_valid && !out_ready;
            held_res = res[PW-1:0];
            held_tag = out_tag;
            if (out_valid && out_ready) begin
                checks++;
                if (res[PW-1:0] !== exp[n_out].data || out_tag !== exp[n_out].tag) begin
                    errors++;
                    $display("[TB] FAIL bp_order[%0d]: got res=%h tag=%0d expected res=%h tag=%0d",
                             n_out, res[PW-1:0], out_tag, exp[n_out].data, exp[n_out].tag);
                end
                n_out++;
            end
            if (in_valid && in_ready) n_in++;
            step();
        end
        checks++;
        if (n_out != 5) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d results expected 5", n_out);
        end
        checks++;
        if (stalls != 4) begin
            errors++;
            $display("[TB] FAIL bp_stall_cycles: got %0d expected 4", stalls);
        end
        drive(1'b0, 1'b0, '0, '0, '0);
        out_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid === 1'b1) extra++;
            step();
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("[TB] FAIL bp_duplicate: got %0d extra results expected 0", extra);
        end
    endtask

    task automatic test_reset_midflight();
        int stale;
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 8'd9, 8'd9, 4'd11);
        step();
        drive(1'b1, 1'b1, 8'hF0, 8'd7, 4'd12);
        step();
        drive(1'b1, 1'b0, 8'd50, 8'd50, 4'd13);
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_inflight: out_valid got %b expected 1", out_valid);
        end
        out_ready = 1'b0;
        reset     = 1'b1;
        drive(1'b1, 1'b0, 8'd1, 8'd2, 4'd14);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, '0, '0, '0);
        checks++;
        if (out_valid !== 1'b0 || res !== '0 || out_tag !== '0) begin
            errors++;
            $display("[TB] FAIL midrst_clear: got v=%b res=%h tag=%0d expected v=0 res=0 tag=0",
                     out_valid, res, out_tag);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready);
        end
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("[TB] FAIL midrst_stale: got %0d stale cycles expected 0", stale);
        end
    endtask

    task automatic test_bubbles();
        logic             exp_v   [4];
        logic [PW-1:0]    exp_res [4];
        logic [TAG_W-1:0] exp_tag [4];
        exp_v[0] = 1'b1; exp_res[0] = 16'h000F; exp_tag[0] = 4'd9;
        exp_v[1] = 1'b0; exp_res[1] = '0;       exp_tag[1] = '0;
        exp_v[2] = 1'b1; exp_res[2] = 16'h0031; exp_tag[2] = 4'd10;
        exp_v[3] = 1'b0; exp_res[3] = '0;       exp_tag[3] = '0;
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 8'd3, 8'd5, 4'd9);
        step();
        drive(1'b0, 1'b0, 8'hAA, 8'h55, 4'd15);
        step();
        drive(1'b1, 1'b0, 8'd7, 8'd7, 4'd10);
        step();
        drive(1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== exp_v[i]) begin
                errors++;
                $display("[TB] FAIL bubble_valid[%0d]: got %b expected %b", i, out_valid, exp_v[i]);
            end
            if (exp_v[i]) begin
                checks++;
                if (res[PW-1:0] !== exp_res[i] || out_tag !== exp_tag[i]) begin
                    errors++;
                    $display("[TB] FAIL bubble_data[%0d]: got res=%h tag=%0d expected res=%h tag=%0d",
                             i, res[PW-1:0], out_tag, exp_res[i], exp_tag[i]);
                end
            end
            step();
        end
    endtask

`ifdef PMULT_ACC_EN
    task automatic test_accumulate();
        logic [RW-1:0] exp_acc [4];
        exp_acc[0] = RW'(12);
        exp_acc[1] = RW'(42);
        exp_acc[2] = RW'(36);
        exp_acc[3] = RW'(1);
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 8'd3, 8'd4, 4'd1);
        in_acc = 1'b0;
        step();
        drive(1'b1, 1'b0, 8'd5, 8'd6, 4'd2);
        in_acc = 1'b1;
        step();
        drive(1'b1, 1'b1, 8'hFE, 8'd3, 4'd3);
        in_acc = 1'b1;
        step();
        drive(1'b1, 1'b0, 8'd1, 8'd1, 4'd4);
        in_acc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || res !== exp_acc[i]) begin
                errors++;
                $display("[TB] FAIL acc[%0d]: got v=%b res=%0d expected v=1 res=%0d",
                         i, out_valid, res, exp_acc[i]);
            end
            step();
            drive(1'b0, 1'b0, '0, '0, '0);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_bubbles();
`ifdef PMULT_ACC_EN
        test_accumulate();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
